bt656_timing_decoder: RTL and testbench

BT656_TIMING_DECODER -- requirements
Module: bt656_timing_decoder

---
 rtl/bt656_pkg.sv | 29 ++
 rtl/bt656_xyz_decoder.sv | 22 ++
 rtl/bt656_timing_decoder.sv | 154 +++++++++++++++
 tb/tb_bt656_timing_decoder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bt656_pkg.sv
// Shared BT.656 constants: timing-reference words, line lengths, XYZ bit positions.
package bt656_pkg;

    localparam logic [9:0]  TRS_ONES           = 10'h3FF;
    localparam logic [9:0]  TRS_ZEROS          = 10'h000;
    localparam logic [10:0] WORDS_PER_LINE_525 = 11'd1716;
    localparam logic [10:0] WORDS_PER_LINE_625 = 11'd1728;
    localparam logic [10:0] ACTIVE_LINE_SIZE   = 11'd1440;

    localparam int XYZ_ONE = 9;
    localparam int XYZ_F   = 8;
    localparam int XYZ_V   = 7;
    localparam int XYZ_H   = 6;
    localparam int XYZ_P3  = 5;
    localparam int XYZ_P0  = 2;

    typedef enum logic [1:0] {
        SEARCH   = 2'd0,
        GOT_3FF  = 2'd1,
        GOT_000A = 2'd2,
        GOT_000B = 2'd3
    } pre_state_t;

    // Protection bits carried in XYZ[5:2] for a given F/V/H triple.
    function automatic logic [3:0] xyz_parity(input logic f, input logic v, input logic h);
        return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

endpackage

// File: rtl/bt656_xyz_decoder.sv
// Combinational XYZ word decoder: extracts F/V/H and checks the protection bits.
module bt656_xyz_decoder
    import bt656_pkg::*;
(
    input  logic [9:0] word,
    output logic       F,
    output logic       V,
    output logic       H,
    output logic       valid
);

    logic unused_lsbs;

    assign F     = word[XYZ_F];
    assign V     = word[XYZ_V];
    assign H     = word[XYZ_H];
    assign valid = word[XYZ_ONE] && (word[XYZ_P3:XYZ_P0] == xyz_parity(F, V, H));

    // The two LSBs carry no timing information.
    assign unused_lsbs = ^word[XYZ_P0-1:0];

endmodule

// File: rtl/bt656_timing_decoder.sv
// BT.656 timing decoder: finds TRS preambles, schedules H/V/F against a 4-word
// delayed stream, counts lines and tracks EAV-to-EAV lock.
//   state    | meaning
//   SEARCH   | no preamble in progress
//   GOT_3FF  | last word was 3FF
//   GOT_000A | saw 3FF,000
//   GOT_000B | saw 3FF,000,000; current word is XYZ
module bt656_timing_decoder
    import bt656_pkg::*;
#(
    parameter int LOCK_LINES      = 2,
    parameter int LINE_COUNT_BITS = 10
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [9:0]                 data_in,
    output logic [9:0]                 data_out,
    output logic                       H,
    output logic                       V,
    output logic                       F,
    output logic [LINE_COUNT_BITS-1:0] line_count,
    output logic                       sync_locked,
    output logic                       xyz_error
);

    localparam int                GOOD_W      = $clog2(LOCK_LINES + 1);
    localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_LINES);
    localparam logic [10:0]       IVL_MAX     = '1;
    localparam logic [1:0]        SAV_DELAY   = 2'd3;

    pre_state_t        state, state_nxt;
    logic [3:0][9:0]   dly;
    logic              dec_f, dec_v, dec_h, dec_valid;
    logic              xyz_slot, eav_ok, sav_ok, xyz_bad;
    logic              pend, pend_v, pend_f;
    logic [1:0]        pend_cnt;
    logic [10:0]       ivl_cnt;
    logic              ivl_good;
    logic [GOOD_W-1:0] good_cnt, good_nxt;

    bt656_xyz_decoder u_xyz (
        .word  (data_in),
        .F     (dec_f),
        .V     (dec_v),
        .H     (dec_h),
        .valid (dec_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dly <= '0;
        else          dly <= {dly[2:0], data_in};
    end
    assign data_out = dly[3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= SEARCH;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = SEARCH;
        case (state)
            SEARCH:   if (data_in == TRS_ONES) state_nxt = GOT_3FF;
            GOT_3FF:  if (data_in == TRS_ONES) state_nxt = GOT_3FF;
                      else if (data_in == TRS_ZEROS) state_nxt = GOT_000A;
            GOT_000A: if (data_in == TRS_ZEROS) state_nxt = GOT_000B;
                      else if (data_in == TRS_ONES) state_nxt = GOT_3FF;
            GOT_000B: if (data_in == TRS_ONES) state_nxt = GOT_3FF;
            default:  state_nxt = SEARCH;
        endcase
    end

    always_comb begin
        xyz_slot = (state == GOT_000B);
        eav_ok   = xyz_slot && dec_valid && dec_h;
        sav_ok   = xyz_slot && dec_valid && !dec_h;
        xyz_bad  = xyz_slot && !dec_valid;
    end

    // EAV flags land when data_out shows the EAV 3FF; SAV flags wait until
    // data_out shows the first active sample, and a later EAV cancels them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            H          <= 1'b1;
            V          <= 1'b1;
            F          <= 1'b0;
            pend       <= 1'b0;
            pend_cnt   <= '0;
            pend_v     <= 1'b0;
            pend_f     <= 1'b0;
            line_count <= '0;
        end else begin
            if (eav_ok) begin
                H    <= 1'b1;
                V    <= dec_v;
                F    <= dec_f;
                pend <= 1'b0;
                if (dec_f != F)            line_count <= '0;
                else if (line_count != '1) line_count <= line_count + 1'b1;
            end else if (pend) begin
                if (pend_cnt == '0) begin
                    H    <= 1'b0;
                    V    <= pend_v;
                    F    <= pend_f;
                    pend <= 1'b0;
                end else begin
                    pend_cnt <= pend_cnt - 1'b1;
                end
            end
            if (sav_ok) begin
                pend     <= 1'b1;
                pend_cnt <= SAV_DELAY;
                pend_v   <= dec_v;
                pend_f   <= dec_f;
            end
        end
    end

    always_comb begin
        ivl_good = (ivl_cnt == WORDS_PER_LINE_525) || (ivl_cnt == WORDS_PER_LINE_625);
        good_nxt = (good_cnt == GOOD_TARGET) ? good_cnt : good_cnt + 1'b1;
    end

    // ivl_cnt == 0 means no EAV seen since reset, so nothing is being measured.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ivl_cnt     <= '0;
            good_cnt    <= '0;
            sync_locked <= 1'b0;
            xyz_error   <= 1'b0;
        end else begin
            xyz_error <= xyz_bad;
            if (eav_ok) begin
                ivl_cnt <= 11'd1;
                if (ivl_cnt != '0) begin
                    if (ivl_good) begin
                        good_cnt    <= good_nxt;
                        sync_locked <= (good_nxt == GOOD_TARGET);
                    end else begin
                        good_cnt    <= '0;
                        sync_locked <= 1'b0;
                    end
                end
            end else if (ivl_cnt != '0 && ivl_cnt != IVL_MAX) begin
                ivl_cnt <= ivl_cnt + 1'b1;
            end
            if (xyz_bad || ivl_cnt == IVL_MAX) begin
                good_cnt    <= '0;
                sync_locked <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bt656_timing_decoder.sv
// Self-checking bench for bt656_timing_decoder: vector table, directed line
// sequences and random streams against a window-matching reference model.
module tb_bt656_timing_decoder;
    import bt656_pkg::*;

    localparam int LOCK = 2;

    logic       clk;
    logic       reset_n;
    logic [9:0] data_in;
    logic [9:0] data_out;
    logic       H, V, F;
    logic [9:0] line_count;
    logic       sync_locked;
    logic       xyz_error;

    bt656_timing_decoder #(.LOCK_LINES(LOCK), .LINE_COUNT_BITS(10)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .data_in     (data_in),
        .data_out    (data_out),
        .H           (H),
        .V           (V),
        .F           (F),
        .line_count  (line_count),
        .sync_locked (sync_locked),
        .xyz_error   (xyz_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // reference model state
    logic [9:0] hist[$];
    logic [9:0] e_do, e_lc;
    logic       e_h, e_v, e_f, e_lock, e_err;
    logic       pv, pf;
    int         cyc = 0;
    int         pend_at = -1;
    int         last_eav = -1;
    int         good = 0;

    typedef struct packed {
        logic [9:0] din;
        logic [9:0] dout;
        logic       h, v, f, err;
        logic [9:0] lc;
    } vec_t;
    vec_t tbl [13];

    function automatic logic [9:0] make_xyz(input logic f, input logic v, input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h, 2'b00};
    endfunction

    function automatic logic [9:0] rand_video();
        return 10'($urandom_range(1, 1022));
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        hist.delete();
        e_do = '0; e_lc = '0;
        e_h = 1'b1; e_v = 1'b1; e_f = 1'b0; e_lock = 1'b0; e_err = 1'b0;
        pend_at = -1; last_eav = -1; good = 0;
    endfunction

    // One clock edge: a timing code is the word following 3FF,000,000 in the
    // last four inputs since reset.
    function automatic void model_edge(input logic [9:0] w);
        logic       f, v, h, valid, trs, eav, sav;
        logic [9:0] ref_code;
        int         d;
        cyc++;
        hist.push_back(w);
        if (hist.size() > 4) void'(hist.pop_front());
        e_do = (hist.size() == 4) ? hist[0] : 10'h000;
        trs  = (hist.size() == 4) && hist[0] == 10'h3FF && hist[1] == 10'h000 && hist[2] == 10'h000;
        f = w[8]; v = w[7]; h = w[6];
        ref_code = make_xyz(f, v, h);
        valid = (w[9:2] == ref_code[9:2]);
        eav   = trs && valid && h;
        sav   = trs && valid && !h;
        e_err = trs && !valid;
        if (eav) begin
            pend_at = -1;
            if (f != e_f)             e_lc = 10'd0;
            else if (e_lc != 10'h3FF) e_lc = 10'(e_lc + 10'd1);
            e_h = 1'b1; e_v = v; e_f = f;
            if (last_eav >= 0) begin
                d = cyc - last_eav;
                if (d == int'(WORDS_PER_LINE_525) || d == int'(WORDS_PER_LINE_625)) good++;
                else good = 0;
            end
            last_eav = cyc;
        end else begin
            if (pend_at == cyc) begin
                e_h = 1'b0; e_v = pv; e_f = pf; pend_at = -1;
            end
            if (last_eav >= 0 && cyc - last_eav >= 2047) good = 0;
        end
        if (sav) begin
            pend_at = cyc + 4; pv = v; pf = f;
        end
        if (e_err) good = 0;
        e_lock = (good >= LOCK);
    endfunction

    function automatic void check_outputs();
        chk("data_out",    32'(data_out),    32'(e_do));
        chk("H",           32'(H),           32'(e_h));
        chk("V",           32'(V),           32'(e_v));
        chk("F",           32'(F),           32'(e_f));
        chk("line_count",  32'(line_count),  32'(e_lc));
        chk("sync_locked", 32'(sync_locked), 32'(e_lock));
        chk("xyz_error",   32'(xyz_error),   32'(e_err));
    endfunction

    task automatic tick(input logic [9:0] w);
        @(negedge clk);
        data_in = w;
        if (!reset_n) model_reset();
        else          model_edge(w);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        repeat (n) tick(rand_video());
        reset_n = 1'b1;
    endtask

    task automatic send_line(input int total, input logic f, input logic v, input logic [9:0] sav_flip);
        logic [9:0] a0, w;
        a0 = '0;
        tick(10'h3FF); tick(10'h000); tick(10'h000); tick(make_xyz(f, v, 1'b1));
        chk("eav_dout_3ff", 32'(data_out), 32'h3FF);
        chk("eav_h_rise",   32'(H),        32'd1);
        repeat (total - 8 - int'(ACTIVE_LINE_SIZE)) tick(rand_video());
        tick(10'h3FF); tick(10'h000); tick(10'h000); tick(make_xyz(f, v, 1'b0) ^ sav_flip);
        if (sav_flip != 10'h000) begin
            chk("bad_sav_err", 32'(xyz_error), 32'd1);
            chk("bad_sav_h",   32'(H),         32'd1);
            chk("bad_sav_v",   32'(V),         32'(v));
            chk("bad_sav_f",   32'(F),         32'(f));
        end
        for (int i = 0; i < int'(ACTIVE_LINE_SIZE); i++) begin
            w = rand_video();
            if (i == 0) a0 = w;
            tick(w);
            if (sav_flip != 10'h000 && i == 0) begin
                chk("err_one_clock", 32'(xyz_error),   32'd0);
                chk("err_unlock",    32'(sync_locked), 32'd0);
            end
            if (sav_flip == 10'h000 && i == 2) chk("h_before_active", 32'(H), 32'd1);
            if (sav_flip == 10'h000 && i == 3) begin
                chk("h_fall",       32'(H),        32'd0);
                chk("first_active", 32'(data_out), 32'(a0));
            end
        end
    endtask

    function automatic logic [9:0] noise_word();
        logic [9:0] w;
        case ($urandom_range(0, 9))
            0, 1, 2: w = 10'h3FF;
            3, 4, 5: w = 10'h000;
            6, 7:    w = make_xyz(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                  1'($urandom_range(0, 1))) | 10'($urandom_range(0, 3));
            default: w = 10'($urandom_range(0, 1023));
        endcase
        return w;
    endfunction

    int         totals [3];
    logic [9:0] flips  [5];
    logic [9:0] flip;

    initial begin
        totals = '{1716, 1728, 1720};
        flips  = '{10'h004, 10'h008, 10'h010, 10'h020, 10'h200};
        tbl[0]  = '{10'h3FF, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0};
        tbl[1]  = '{10'h3FF, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0};
        tbl[2]  = '{10'h000, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0};
        tbl[3]  = '{10'h000, 10'h3FF, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0};
        tbl[4]  = '{10'h3C4, 10'h3FF, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0};
        tbl[5]  = '{10'h123, 10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0};
        tbl[6]  = '{10'h3FF, 10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0};
        tbl[7]  = '{10'h000, 10'h3C4, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0};
        tbl[8]  = '{10'h123, 10'h123, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0};
        tbl[9]  = '{10'h000, 10'h3FF, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0};
        tbl[10] = '{10'h000, 10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0};
        tbl[11] = '{10'h000, 10'h123, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0};
        tbl[12] = '{10'h000, 10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0};

        reset_n = 1'b0;
        data_in = 10'h000;
        model_reset();
        repeat (3) tick(rand_video());
        chk("rst_data_out", 32'(data_out),    32'd0);
        chk("rst_H",        32'(H),           32'd1);
        chk("rst_V",        32'(V),           32'd1);
        chk("rst_F",        32'(F),           32'd0);
        chk("rst_lc",       32'(line_count),  32'd0);
        chk("rst_lock",     32'(sync_locked), 32'd0);
        chk("rst_err",      32'(xyz_error),   32'd0);
        reset_n = 1'b1;

        // preamble with repeated 3FF, then a 3FF,000,123 false start
        for (int i = 0; i < 13; i++) begin
            tick(tbl[i].din);
            chk("tbl_dout", 32'(data_out),   32'(tbl[i].dout));
            chk("tbl_H",    32'(H),          32'(tbl[i].h));
            chk("tbl_V",    32'(V),          32'(tbl[i].v));
            chk("tbl_F",    32'(F),          32'(tbl[i].f));
            chk("tbl_err",  32'(xyz_error),  32'(tbl[i].err));
            chk("tbl_lc",   32'(line_count), 32'(tbl[i].lc));
        end

        pulse_reset(3);
        send_line(1716, 1'b0, 1'b0, 10'h000);
        send_line(1716, 1'b0, 1'b0, 10'h000);
        chk("lock_after_1_good", 32'(sync_locked), 32'd0);
        send_line(1716, 1'b0, 1'b0, 10'h000);
        chk("lock_after_2_good", 32'(sync_locked), 32'd1);

        send_line(1716, 1'b0, 1'b1, 10'h020);
        send_line(1716, 1'b0, 1'b1, 10'h000);
        chk("relock_1", 32'(sync_locked), 32'd0);
        send_line(1716, 1'b0, 1'b1, 10'h000);
        chk("relock_2", 32'(sync_locked), 32'd1);

        send_line(1720, 1'b0, 1'b0, 10'h000);
        send_line(1716, 1'b0, 1'b0, 10'h000);
        chk("bad_interval_unlock", 32'(sync_locked), 32'd0);
        send_line(1716, 1'b0, 1'b0, 10'h000);
        chk("after_bad_1", 32'(sync_locked), 32'd0);
        send_line(1716, 1'b0, 1'b0, 10'h000);
        chk("after_bad_2", 32'(sync_locked), 32'd1);

        send_line(1716, 1'b1, 1'b0, 10'h000);
        chk("field_change_lc", 32'(line_count), 32'd0);
        send_line(1716, 1'b1, 1'b0, 10'h000);
        chk("same_field_lc", 32'(line_count), 32'd1);

        // reset in the middle of an active line
        tick(10'h3FF); tick(10'h000); tick(10'h000); tick(make_xyz(1'b1, 1'b1, 1'b0));
        repeat (700) tick(rand_video());
        pulse_reset(3);
        repeat (300) tick(rand_video());
        chk("post_rst_H",    32'(H),           32'd1);
        chk("post_rst_V",    32'(V),           32'd1);
        chk("post_rst_F",    32'(F),           32'd0);
        chk("post_rst_lock", 32'(sync_locked), 32'd0);
        send_line(1728, 1'b0, 1'b0, 10'h000);
        send_line(1728, 1'b0, 1'b0, 10'h000);
        chk("post_rst_1_good", 32'(sync_locked), 32'd0);
        send_line(1728, 1'b0, 1'b0, 10'h000);
        chk("post_rst_2_good", 32'(sync_locked), 32'd1);

        repeat (2100) tick(rand_video());
        chk("saturation_unlock", 32'(sync_locked), 32'd0);

        for (int i = 0; i < 6; i++) begin
            flip = ($urandom_range(0, 3) == 0) ? flips[$urandom_range(0, 4)] : 10'h000;
            send_line(totals[$urandom_range(0, 2)], 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), flip);
        end

        repeat (4000) tick(noise_word());

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
